adder_rr_arbiter: RTL and testbench

Round-robin arbiter and result buffer that shares one combinational adder among several requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the sum, carry-out and requester ID into a single-entry output buffer, and holds the result until the consumer yumis it. It sits between the lab's requester-side test logic and the adder datapath.

---
 rtl/adder_rr_arbiter_pkg.sv | 31 +++
 rtl/adder_core.sv | 13 +
 rtl/adder_rr_arbiter.sv | 98 +++++++++
 tb/tb_adder_rr_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/adder_rr_arbiter_pkg.sv
// Shared types and the round-robin grant helper for the adder arbiter.
package adder_rr_arbiter_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  localparam int max_req_lp = 32;

  // Index of the first set bit of v, scanning ptr, ptr+1, ... modulo n.
  // Returns 0 when nothing is set; callers qualify with |v.
  function automatic int unsigned rr_grant(input logic [max_req_lp-1:0] v,
                                           input int unsigned n,
                                           input int unsigned ptr);
    int unsigned g;
    int unsigned idx;
    logic        found;
    g     = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < max_req_lp; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && v[idx[4:0]]) begin
          g     = idx;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/adder_core.sv
// Unsigned adder: zero-extended a+b, carry is the extra top bit.
module adder_core #(
  parameter int width_p = 4
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic [width_p-1:0] sum_o,
  output logic               carry_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one adder among requesters, with a single-entry
// result buffer drained by a valid/yumi consumer.
module adder_rr_arbiter
  import adder_rr_arbiter_pkg::*;
#(
  parameter  int width_p     = 4,
  parameter  int num_req_p   = 4,
  localparam int id_width_lp = $clog2(num_req_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_req_p-1:0]         req_v_i,
  input  logic [num_req_p*width_p-1:0] req_a_i,
  input  logic [num_req_p*width_p-1:0] req_b_i,
  output logic [num_req_p-1:0]         req_ready_o,
  output logic                         result_v_o,
  output logic [width_p-1:0]           result_sum_o,
  output logic                         result_carry_o,
  output logic [id_width_lp-1:0]       result_id_o,
  input  logic                         result_yumi_i
);

  state_e                 state_q, state_d;
  logic [width_p-1:0]     sum_q, sum_d;
  logic                   carry_q, carry_d;
  logic [id_width_lp-1:0] id_q, id_d;
  logic [id_width_lp-1:0] rr_ptr_q, rr_ptr_d;

  logic [max_req_lp-1:0]  v_ext;
  logic [id_width_lp-1:0] grant_id;
  logic [width_p-1:0]     a_sel, b_sel, core_sum;
  logic                   core_carry;
  logic                   accept, xfer;

  assign v_ext    = max_req_lp'(req_v_i);
  assign grant_id = id_width_lp'(rr_grant(v_ext, int'(num_req_p), int'(rr_ptr_q)));
  assign accept   = (state_q == EMPTY) | result_yumi_i;
  assign a_sel    = req_a_i[grant_id*width_p +: width_p];
  assign b_sel    = req_b_i[grant_id*width_p +: width_p];

  adder_core #(.width_p(width_p)) u_core (
    .a_i    (a_sel),
    .b_i    (b_sel),
    .sum_o  (core_sum),
    .carry_o(core_carry)
  );

  // Ready is held low during reset so nothing is accepted into a buffer being cleared.
  always_comb begin
    req_ready_o = '0;
    if (!reset_i && accept) begin
      for (int k = 0; k < num_req_p; k++) begin
        if (grant_id == id_width_lp'(k) && req_v_i[k]) req_ready_o[k] = 1'b1;
      end
    end
  end

  assign xfer = |req_ready_o;

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      state_d  = FULL;
      sum_d    = core_sum;
      carry_d  = core_carry;
      id_d     = grant_id;
      rr_ptr_d = (grant_id == id_width_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
    end else if (state_q == FULL && result_yumi_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= EMPTY;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign result_v_o     = (state_q == FULL);
  assign result_sum_o   = sum_q;
  assign result_carry_o = carry_q;
  assign result_id_o    = id_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed and random checks of adder_rr_arbiter against a cycle-level model.
module tb_adder_rr_arbiter;
  localparam int W = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N-1:0]   req_v_i;
  logic [N*W-1:0] req_a_i, req_b_i;
  logic [N-1:0]   req_ready_o;
  logic           result_v_o, result_carry_o, result_yumi_i;
  logic [W-1:0]   result_sum_o;
  logic [1:0]     result_id_o;

  adder_rr_arbiter #(.width_p(W), .num_req_p(N)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i), .req_a_i(req_a_i),
    .req_b_i(req_b_i), .req_ready_o(req_ready_o), .result_v_o(result_v_o),
    .result_sum_o(result_sum_o), .result_carry_o(result_carry_o),
    .result_id_o(result_id_o), .result_yumi_i(result_yumi_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_illegal = 0;
  int m_v = 0, m_sum = 0, m_carry = 0, m_id = 0, m_ptr = 0;
  int last_g = -1;
  bit auto_yumi = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs are already driven at a negedge; check ready, advance model, check outputs.
  task automatic step(input string tag);
    int g, acc, full, a, b;
    logic [N-1:0] exp_rdy;
    if (auto_yumi) result_yumi_i = (m_v != 0);
    if (result_yumi_i && m_v == 0 && !reset_i) n_illegal++;
    #1;
    g = -1;
    for (int i = 0; i < N; i++)
      if (g < 0 && req_v_i[(m_ptr + i) % N]) g = (m_ptr + i) % N;
    acc = (m_v == 0) || result_yumi_i;
    exp_rdy = '0;
    if (!reset_i && acc && g >= 0) exp_rdy[g] = 1'b1;
    chk({tag, ".ready"}, 32'(req_ready_o), 32'(exp_rdy));
    last_g = (exp_rdy != 0) ? g : -1;
    if (reset_i) begin
      m_v = 0; m_sum = 0; m_carry = 0; m_id = 0; m_ptr = 0;
    end else if (last_g >= 0) begin
      a = int'(req_a_i[g*W +: W]);
      b = int'(req_b_i[g*W +: W]);
      full = a + b;
      m_v = 1; m_sum = full % (1 << W); m_carry = full >> W; m_id = g;
      m_ptr = (g + 1) % N;
    end else if (result_yumi_i && m_v != 0) begin
      m_v = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".v"},     32'(result_v_o),     32'(m_v));
    chk({tag, ".sum"},   32'(result_sum_o),   32'(m_sum));
    chk({tag, ".carry"}, 32'(result_carry_o), 32'(m_carry));
    chk({tag, ".id"},    32'(result_id_o),    32'(m_id));
  endtask

  task automatic set_req(input int k, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    req_v_i[k] = v;
    req_a_i[k*W +: W] = a;
    req_b_i[k*W +: W] = b;
  endtask

  initial begin
    reset_i = 1'b1; req_v_i = '0; req_a_i = '0; req_b_i = '0; result_yumi_i = 1'b0;
    @(negedge clk);
    step("reset");
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) step("idle");

    // Single requester 2: 8+7 = 15, no carry.
    auto_yumi = 1;
    set_req(2, 1'b1, 4'b1000, 4'b0111);
    step("req2");
    set_req(2, 1'b0, 4'h0, 4'h0);
    // Requester 0: 8+8 wraps to 0 with carry.
    set_req(0, 1'b1, 4'b1000, 4'b1000);
    step("req0");
    set_req(0, 1'b0, 4'h0, 4'h0);
    step("drain");

    // Fresh pointer, everyone valid: grants should rotate 0,1,2,3,0.
    reset_i = 1'b1; step("rst2"); reset_i = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 4'(k + 3), 4'(2 * k + 1));
    for (int i = 0; i < 5; i++) step("rotate");

    // Stall the consumer for three cycles, then release.
    auto_yumi = 0; result_yumi_i = 1'b0;
    for (int i = 0; i < 3; i++) step("stall");
    result_yumi_i = 1'b1;
    step("release");

    // Get the pointer to 3 (grant id 2), hold FULL, then reset.
    result_yumi_i = 1'b1;
    set_req(0, 1'b0, 4'h0, 4'h0); set_req(1, 1'b0, 4'h0, 4'h0); set_req(3, 1'b0, 4'h0, 4'h0);
    step("to_ptr3");
    result_yumi_i = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 4'(k + 9), 4'(k));
    step("full_hold");
    reset_i = 1'b1; step("mid_reset"); reset_i = 1'b0;
    auto_yumi = 1;
    step("post_reset");
    chk("post_reset.first_id", 32'(result_id_o), 32'd0);

    // Random traffic honouring the hold-until-ready rule.
    auto_yumi = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++)
        if (!req_v_i[k] || last_g == k)
          set_req(k, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
      result_yumi_i = (m_v != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      step("rand");
    end

    if (n_illegal != 0) $display("note: %0d illegal yumi-while-empty cycles driven", n_illegal);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
